quad_enc_ctrl: RTL and testbench
================================

Name: quad_enc_ctrl

Overview:
Sequencing controller for the quadrature decoder.
- Owns the decoder's active-low reset and its multiplier setting.
- Runs a homing sequence that zeroes the count on an index pulse.
- Latches decoder faults and recovers from them.
- Produces periodic position/velocity snapshots on a valid/ready stream for the motion loop.

Parameters:
encbits, 64, width of decoder count and of s_pos/s_delta
period_bits, 16, width of sample period input
home_timeout, 50000000, max cycles to wait for index during homing
rst_cycles, 2, cycles enc_resetn is held low per decoder reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = sample stream running
period  in  period_bits  sample interval in clk cycles; 0 = sampling off
mult_cfg  in  8  requested decoder multiplier
home_req  in  1  one-cycle pulse: start homing
fault_clr  in  1  one-cycle pulse: clear fault, reset decoder
stat_clr  in  1  one-cycle pulse: clear overrun and home_err
index  in  1  asynchronous encoder index (Z) input
enc_count  in  encbits  signed decoder count
enc_faultn  in  1  decoder fault, active low
enc_resetn  out  1  decoder reset, active low
enc_multiplier  out  8  multiplier driven to decoder
s_valid  out  1  snapshot available
s_ready  in  1  consumer accepts snapshot
s_pos  out  encbits  signed count at sample tick
s_delta  out  encbits  signed count change since previous tick
homed  out  1  sticky: homing completed
fault  out  1  sticky: enc_faultn seen low
overrun  out  1  sticky: unconsumed snapshot overwritten
home_err  out  1  sticky: homing timed out
busy  out  1  state is HOME_WAIT or ENC_RST

Behaviour:
- Reset values:
  - state = ENC_RST with rst timer loaded, so enc_resetn = 0 for rst_cycles after reset release.
  - enc_multiplier = 1.
  - s_valid = 0, s_pos = 0, s_delta = 0.
  - All sticky flags = 0.
  - Timers = 0.
  - prev_count = 0.
- index passes through a 2-FF synchronizer plus an edge register. idx_rise = synced 0 -> 1.
- States:
  - IDLE: sampling off.
  - RUN: sampling active.
  - HOME_WAIT: waiting for index.
  - ENC_RST: enc_resetn = 0.
- Transitions (priority fault_clr > home_req > local condition):
  - Any state, fault_clr -> ENC_RST; clears fault.
  - IDLE/RUN, home_req -> HOME_WAIT; clears homed; loads timeout counter.
  - home_req while in HOME_WAIT or ENC_RST is ignored.
  - IDLE -> RUN when enable = 1 and period != 0.
  - RUN -> IDLE when enable = 0 or period = 0.
  - HOME_WAIT, idx_rise -> ENC_RST; sets homed on exit of ENC_RST.
  - HOME_WAIT, timeout counter reaches 0 -> IDLE; sets home_err.
  - ENC_RST after rst_cycles -> RUN if enable and period != 0, else IDLE.
- On exit of ENC_RST: prev_count = 0, sample timer reloaded.
- enc_multiplier loads mult_cfg only while in IDLE or ENC_RST. It holds in RUN/HOME_WAIT, so there is no scale change mid-run.
- fault is set on any cycle enc_faultn = 0, except during ENC_RST and the cycle after it. It stays set until fault_clr. Sampling continues while fault is set.
- Sample timer (RUN only):
  - Down-counter loaded with period-1.
  - tick when it reaches 0, then reload.
  - Timer is frozen in other states.
  - A period change takes effect at the next reload.
- On tick:
  - s_pos <= enc_count.
  - s_delta <= enc_count - prev_count, modulo 2^encbits (wrap, no saturation).
  - prev_count <= enc_count.
  - s_valid <= 1.
  - Data is visible the cycle after tick (latency 1).
- Handshake:
  - Transfer occurs when s_valid and s_ready are both 1.
  - s_valid drops the next cycle unless a tick coincides.
  - Data is stable while s_valid = 1 and s_ready = 0, except on overrun.
  - Tick while s_valid = 1 and s_ready = 0: overwrite data, keep s_valid, set overrun.
  - Tick in the same cycle as a transfer: new data loads, s_valid stays 1, no overrun.
- Entering ENC_RST clears s_valid. A pending snapshot is discarded without overrun.
- stat_clr clears overrun and home_err. A set in the same cycle wins over the clear.
- Async reset mid-operation returns everything to reset values immediately.

Test Plan:
1. Reset release, enable = 1, period = 4, enc_count ramps +1/clk from 0, s_ready = 1 -> enc_resetn low 2 cycles, then s_valid every 4 cycles, s_delta = 4, s_pos increasing by 4.
2. s_ready = 0 for 10 cycles, period = 4 -> overrun = 1, s_pos = latest tick value, s_valid held; stat_clr -> overrun = 0.
3. home_req, index pulse after 100 cycles -> busy = 1, enc_resetn low exactly 2 cycles after synchronized edge, homed = 1, next s_delta measured from 0.
4. home_req with no index, home_timeout = 1000 -> state IDLE after 1000 cycles, home_err = 1, homed = 0, enc_resetn never asserted.
5. enc_faultn = 0 one cycle in RUN -> fault = 1 sticky; fault_clr with home_req in the same cycle -> ENC_RST (fault_clr wins), fault = 0.
6. enc_count 0x7FFF...FFFF then 0x8000...0001 across a tick -> s_delta = 2 (wrap). mult_cfg change in RUN -> enc_multiplier unchanged until next IDLE/ENC_RST.

Source files
------------

// File: rtl/quad_enc_ctrl.sv
// Sequencing controller for a quadrature decoder: decoder reset/multiplier ownership,
// index homing, fault latching and periodic position/velocity snapshots on a valid/ready stream.
module quad_enc_ctrl #(
   parameter int encbits      = 64,
   parameter int period_bits  = 16,
   parameter int home_timeout = 50000000,
   parameter int rst_cycles   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [period_bits-1:0] period,
   input  logic [7:0]             mult_cfg,
   input  logic                   home_req,
   input  logic                   fault_clr,
   input  logic                   stat_clr,
   input  logic                   index,
   input  logic [encbits-1:0]     enc_count,
   input  logic                   enc_faultn,
   output logic                   enc_resetn,
   output logic [7:0]             enc_multiplier,
   output logic                   s_valid,
   input  logic                   s_ready,
   output logic [encbits-1:0]     s_pos,
   output logic [encbits-1:0]     s_delta,
   output logic                   homed,
   output logic                   fault,
   output logic                   overrun,
   output logic                   home_err,
   output logic                   busy
);

   localparam int HTW = $clog2(home_timeout + 1);
   localparam int RTW = $clog2(rst_cycles + 1);

   typedef enum logic [1:0] {IDLE, RUN, HOME_WAIT, ENC_RST} state_t;

   state_t                 state, state_nx;
   logic [RTW-1:0]         rst_tmr;
   logic [HTW-1:0]         home_tmr;
   logic [period_bits-1:0] samp_tmr;
   logic [encbits-1:0]     prev_count;
   logic                   idx_s1, idx_s2, idx_d, idx_rise;
   logic                   rst_dly, home_pend;
   logic                   run_ok, enter_rst, rst_exit, enter_home, home_to, tick;

   assign idx_rise = idx_s2 & ~idx_d;
   assign run_ok   = enable && (period != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ENC_RST;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (fault_clr) state_nx = ENC_RST;
      else begin
         case (state)
            IDLE:      if (home_req) state_nx = HOME_WAIT;
                       else if (run_ok) state_nx = RUN;
            RUN:       if (home_req) state_nx = HOME_WAIT;
                       else if (!run_ok) state_nx = IDLE;
            HOME_WAIT: if (idx_rise) state_nx = ENC_RST;
                       else if (home_tmr == '0) state_nx = IDLE;
            ENC_RST:   if (rst_tmr == '0) state_nx = run_ok ? RUN : IDLE;
            default:   state_nx = ENC_RST;
         endcase
      end
   end

   always_comb begin
      enc_resetn = (state != ENC_RST);
      busy       = (state == HOME_WAIT) || (state == ENC_RST);
      // fault_clr while already in ENC_RST restarts the reset pulse
      enter_rst  = (state_nx == ENC_RST) && ((state != ENC_RST) || fault_clr);
      rst_exit   = (state == ENC_RST) && (state_nx != ENC_RST);
      enter_home = (state_nx == HOME_WAIT) && (state != HOME_WAIT);
      home_to    = (state == HOME_WAIT) && (state_nx == IDLE);
      tick       = (state == RUN) && (samp_tmr == '0) && (state_nx != ENC_RST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_s1   <= 1'b0;
         idx_s2   <= 1'b0;
         idx_d    <= 1'b0;
         rst_tmr  <= RTW'(rst_cycles - 1);
         home_tmr <= '0;
         samp_tmr <= '0;
      end else begin
         idx_s1 <= index;
         idx_s2 <= idx_s1;
         idx_d  <= idx_s2;
         if (enter_rst)                              rst_tmr <= RTW'(rst_cycles - 1);
         else if (state == ENC_RST && rst_tmr != '0) rst_tmr <= rst_tmr - 1'b1;
         if (enter_home)                                 home_tmr <= HTW'(home_timeout - 1);
         else if (state == HOME_WAIT && home_tmr != '0)  home_tmr <= home_tmr - 1'b1;
         if (rst_exit) samp_tmr <= period - 1'b1;
         else if (state == RUN) samp_tmr <= (samp_tmr == '0) ? period - 1'b1 : samp_tmr - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_count     <= '0;
         s_pos          <= '0;
         s_delta        <= '0;
         s_valid        <= 1'b0;
         overrun        <= 1'b0;
         home_err       <= 1'b0;
         homed          <= 1'b0;
         home_pend      <= 1'b0;
         fault          <= 1'b0;
         rst_dly        <= 1'b1;
         enc_multiplier <= 8'd1;
      end else begin
         rst_dly <= (state == ENC_RST);
         if (state == IDLE || state == ENC_RST) enc_multiplier <= mult_cfg;

         if (rst_exit)  prev_count <= '0;
         else if (tick) prev_count <= enc_count;
         if (tick) begin
            s_pos   <= enc_count;
            s_delta <= enc_count - prev_count;
         end

         // a tick coinciding with a transfer keeps valid high with fresh data
         if (enter_rst)    s_valid <= 1'b0;
         else if (tick)    s_valid <= 1'b1;
         else if (s_ready) s_valid <= 1'b0;

         if (tick && s_valid && !s_ready) overrun <= 1'b1;
         else if (stat_clr)               overrun <= 1'b0;
         if (home_to)       home_err <= 1'b1;
         else if (stat_clr) home_err <= 1'b0;

         // homed is only credited for the decoder reset triggered by the index
         if (enter_rst) home_pend <= (state == HOME_WAIT) && !fault_clr;
         if (enter_home)                 homed <= 1'b0;
         else if (rst_exit && home_pend) homed <= 1'b1;

         // decoder fault pin is ignored while it is held in reset and one cycle after
         if (fault_clr) fault <= 1'b0;
         else if (!enc_faultn && state != ENC_RST && !rst_dly) fault <= 1'b1;
      end
   end

endmodule

// File: tb/tb_quad_enc_ctrl.sv
// Directed bench for quad_enc_ctrl: startup sampling, overrun, homing, timeout,
// fault handling, count wrap and multiplier hold, async reset.
module tb_quad_enc_ctrl;

   logic        clk = 1'b0;
   logic        reset, enable, home_req, fault_clr, stat_clr, index, enc_faultn, s_ready;
   logic [15:0] period;
   logic [7:0]  mult_cfg, enc_multiplier;
   logic [63:0] enc_count, s_pos, s_delta;
   logic        enc_resetn, s_valid, homed, fault, overrun, home_err, busy;
   logic        ramp, rst_seen;
   int          total = 0;
   int          bad = 0;

   quad_enc_ctrl #(.encbits(64), .period_bits(16), .home_timeout(1000), .rst_cycles(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .period(period), .mult_cfg(mult_cfg),
      .home_req(home_req), .fault_clr(fault_clr), .stat_clr(stat_clr), .index(index),
      .enc_count(enc_count), .enc_faultn(enc_faultn), .enc_resetn(enc_resetn),
      .enc_multiplier(enc_multiplier), .s_valid(s_valid), .s_ready(s_ready),
      .s_pos(s_pos), .s_delta(s_delta), .homed(homed), .fault(fault),
      .overrun(overrun), .home_err(home_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ramp) enc_count = enc_count + 64'd1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; period = 16'd4; mult_cfg = 8'd3; home_req = 1'b0;
      fault_clr = 1'b0; stat_clr = 1'b0; index = 1'b0; enc_faultn = 1'b1; s_ready = 1'b1;
      enc_count = '0; ramp = 1'b0; rst_seen = 1'b0;

      // reset state
      step(3);
      chk("rst_resetn", enc_resetn, 0);
      chk("rst_mult", enc_multiplier, 1);
      chk("rst_valid", s_valid, 0);
      chk("rst_pos", s_pos, 0);
      chk("rst_flags", {homed, fault, overrun, home_err}, 0);
      chk("rst_busy", busy, 1);

      // 1: startup sampling, count ramps 1/clk
      reset = 1'b0; ramp = 1'b1;
      step();
      chk("t1_resetn_low", enc_resetn, 0);
      chk("t1_mult_load", enc_multiplier, 3);
      step();
      chk("t1_resetn_high", enc_resetn, 1);
      chk("t1_busy", busy, 0);
      step(4);
      chk("t1_valid1", s_valid, 1);
      chk("t1_pos1", s_pos, 5);
      chk("t1_delta1", s_delta, 5);
      step();
      chk("t1_valid_drop", s_valid, 0);
      step(3);
      chk("t1_pos2", s_pos, 9);
      chk("t1_delta2", s_delta, 4);
      step(4);
      chk("t1_pos3", s_pos, 13);

      // 2: stalled consumer -> overrun, then transfer coinciding with tick
      s_ready = 1'b0;
      step(10);
      chk("t2_valid_held", s_valid, 1);
      chk("t2_pos_latest", s_pos, 21);
      chk("t2_delta", s_delta, 4);
      chk("t2_overrun", overrun, 1);
      stat_clr = 1'b1;
      step();
      chk("t2_stat_clr", overrun, 0);
      stat_clr = 1'b0; s_ready = 1'b1;
      step();
      chk("t2_xfer_tick_valid", s_valid, 1);
      chk("t2_xfer_tick_pos", s_pos, 25);
      chk("t2_xfer_tick_ovr", overrun, 0);
      step();
      chk("t2_valid_drop", s_valid, 0);

      // 3: homing with index after 100 cycles
      home_req = 1'b1;
      step();
      home_req = 1'b0;
      chk("t3_busy", busy, 1);
      chk("t3_homed_clr", homed, 0);
      step(100);
      index = 1'b1;
      step(2);
      chk("t3_sync_resetn", enc_resetn, 1);
      step();
      chk("t3_rst_c1", enc_resetn, 0);
      index = 1'b0;
      step();
      chk("t3_rst_c2", enc_resetn, 0);
      step();
      chk("t3_rst_done", enc_resetn, 1);
      chk("t3_homed", homed, 1);
      step(4);
      chk("t3_valid", s_valid, 1);
      chk("t3_pos", s_pos, 136);
      chk("t3_delta_from0", s_delta, 136);
      step();

      // 4: homing timeout
      home_req = 1'b1;
      step();
      home_req = 1'b0;
      chk("t4_busy", busy, 1);
      chk("t4_homed_clr", homed, 0);
      for (int i = 0; i < 999; i++) begin
         step();
         if (enc_resetn !== 1'b1) rst_seen = 1'b1;
      end
      chk("t4_no_enc_rst", rst_seen, 0);
      chk("t4_still_wait", busy, 1);
      step();
      chk("t4_left_wait", busy, 0);
      chk("t4_home_err", home_err, 1);
      chk("t4_homed", homed, 0);
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      chk("t4_err_clr", home_err, 0);

      // 5: fault latch, fault_clr beats home_req, fault masked around decoder reset
      enc_faultn = 1'b0;
      step();
      enc_faultn = 1'b1;
      chk("t5_fault_set", fault, 1);
      step(2);
      chk("t5_fault_sticky", fault, 1);
      fault_clr = 1'b1; home_req = 1'b1; enc_faultn = 1'b0;
      step();
      fault_clr = 1'b0; home_req = 1'b0;
      chk("t5_enc_rst", enc_resetn, 0);
      chk("t5_fault_clr", fault, 0);
      step();
      chk("t5_rst_c2", enc_resetn, 0);
      step();
      chk("t5_rst_done", enc_resetn, 1);
      chk("t5_not_homed", homed, 0);
      chk("t5_mask_rst", fault, 0);
      ramp = 1'b0; enc_count = 64'h7FFF_FFFF_FFFF_FFFF;
      step();
      chk("t5_mask_after", fault, 0);
      enc_faultn = 1'b1;

      // 6: wrap across a tick, multiplier held in RUN
      step(3);
      chk("t6_pos_max", s_pos, 64'h7FFF_FFFF_FFFF_FFFF);
      chk("t6_delta_max", s_delta, 64'h7FFF_FFFF_FFFF_FFFF);
      enc_count = 64'h8000_0000_0000_0001; mult_cfg = 8'd5;
      step(4);
      chk("t6_pos_wrap", s_pos, 64'h8000_0000_0000_0001);
      chk("t6_delta_wrap", s_delta, 2);
      chk("t6_mult_hold", enc_multiplier, 3);
      enable = 1'b0;
      step();
      chk("t6_mult_hold2", enc_multiplier, 3);
      step();
      chk("t6_mult_idle", enc_multiplier, 5);

      // async reset mid-operation
      #2 reset = 1'b1;
      #2;
      chk("ar_pos", s_pos, 0);
      chk("ar_mult", enc_multiplier, 1);
      chk("ar_resetn", enc_resetn, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
